// File: rtl/state_clk_pkg.sv
// state_clk_pkg: shared FSM encoding and default timing constants for the state clock monitor
package state_clk_pkg;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, LOST} state_t;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_EXP_HALF = 5000001;
  localparam int DEF_TOL = 1024;
  localparam int DEF_LOCK_EDGES = 2;
endpackage

// File: rtl/state_clk_monitor_if.sv
// state_clk_monitor_if: slow state clock input plus tick, measurement and lock status outputs
interface state_clk_monitor_if #(parameter int CNT_W = 24);
  logic state_clk;
  logic tick_rise;
  logic tick_fall;
  logic [CNT_W-1:0] half_period;
  logic meas_valid;
  logic locked;
  logic lost;
  logic [15:0] edge_count;
  modport master (output state_clk, input tick_rise, tick_fall, half_period, meas_valid, locked, lost, edge_count);
  modport slave (input state_clk, output tick_rise, tick_fall, half_period, meas_valid, locked, lost, edge_count);
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus delay flop, decoding rise/fall/change of an async level
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic change
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {d, s1, s2};
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign change = s2 ^ s3;
endmodule

// File: rtl/state_clk_monitor.sv
// state_clk_monitor: samples the divided state clock, measures each half-period and runs a lock/loss watchdog
module state_clk_monitor
  import state_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int EXP_HALF = DEF_EXP_HALF,
  parameter int TOL = DEF_TOL,
  parameter int LOCK_EDGES = DEF_LOCK_EDGES
) (
  input logic clkin,
  input logic rst,
  state_clk_monitor_if.slave mon
);
  localparam int GW = $clog2(LOCK_EDGES + 1);
  localparam logic [CNT_W-1:0] LO = CNT_W'(EXP_HALF - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(EXP_HALF + TOL);
  state_t state;
  logic [CNT_W-1:0] cnt, meas;
  logic [GW-1:0] good;
  logic rise, fall, change, in_tol, timeout;
  sync_edge_det u_sync (.clk(clkin), .rst(rst), .d(mon.state_clk), .rise(rise), .fall(fall), .change(change));
  assign meas = &cnt ? cnt : cnt + CNT_W'(1);
  assign in_tol = meas >= LO && meas <= HI;
  assign timeout = cnt == HI && !change;
  always_ff @(posedge clkin or posedge rst)
    if (rst) begin
      state <= SEARCH;
      cnt <= '0;
      good <= '0;
      mon.tick_rise <= 1'b0;
      mon.tick_fall <= 1'b0;
      mon.half_period <= '0;
      mon.meas_valid <= 1'b0;
      mon.locked <= 1'b0;
      mon.lost <= 1'b0;
      mon.edge_count <= '0;
    end else begin
      mon.tick_rise <= rise;
      mon.tick_fall <= fall;
      mon.meas_valid <= 1'b0;
      mon.locked <= state == LOCKED;
      mon.lost <= state == LOST;
      cnt <= change ? '0 : meas;
      if (change) mon.edge_count <= mon.edge_count + 16'd1;
      // The first interval after SEARCH is partial, so only later states publish a measurement
      if (change && state != SEARCH) begin
        mon.half_period <= meas;
        mon.meas_valid <= 1'b1;
      end
      case (state)
        SEARCH: if (change) state <= ACQUIRE;
        ACQUIRE:
          if (change) begin
            if (!in_tol) good <= '0;
            else if (good == GW'(LOCK_EDGES - 1)) begin
              good <= '0;
              state <= LOCKED;
            end else good <= good + GW'(1);
          end else if (timeout) begin
            good <= '0;
            state <= SEARCH;
          end
        LOCKED: if ((change && !in_tol) || timeout) state <= LOST;
        LOST:
          if (change) begin
            good <= '0;
            state <= ACQUIRE;
          end
      endcase
    end
endmodule

// File: tb/tb_state_clk_monitor.sv
// tb_state_clk_monitor: randomized and directed checks of the state clock monitor against an interval-based model
module tb_state_clk_monitor;
  localparam int W = 8, EXP = 10, TOL = 1, LE = 2, SAT = 255;
  localparam int S_SEARCH = 0, S_ACQ = 1, S_LOCKED = 2, S_LOST = 3;
  logic clk = 0, rst = 0;
  int n_chk = 0, n_fail = 0, since = 0, mv_cnt = 0;
  int k, good, st, meas, m_half, m_ecnt;
  bit d1, d2, d3, e, tmo, intol;
  logic m_rise, m_fall, m_mv, m_locked, m_lost;

  state_clk_monitor_if #(.CNT_W(W)) bus ();
  state_clk_monitor #(.CNT_W(W), .EXP_HALF(EXP), .TOL(TOL), .LOCK_EDGES(LE)) dut (
    .clkin(clk), .rst(rst), .mon(bus)
  );

  always #5 clk = ~clk;

  // Model: edges are state_clk seen two vs three samples back; k counts cycles since the last edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; good = 0; st = S_SEARCH; d1 = 0; d2 = 0; d3 = 0;
      m_rise = 0; m_fall = 0; m_mv = 0; m_locked = 0; m_lost = 0; m_half = 0; m_ecnt = 0;
    end else begin
      e = d2 != d3;
      m_rise = d2 && !d3;
      m_fall = !d2 && d3;
      m_locked = st == S_LOCKED;
      m_lost = st == S_LOST;
      k++;
      meas = k > SAT ? SAT : k;
      tmo = !e && k == EXP + TOL + 1;
      intol = meas >= EXP - TOL && meas <= EXP + TOL;
      m_mv = e && st != S_SEARCH;
      if (m_mv) m_half = meas;
      if (e) begin
        m_ecnt = (m_ecnt + 1) % 65536;
        k = 0;
      end
      if (st == S_SEARCH) begin
        if (e) st = S_ACQ;
      end else if (st == S_ACQ) begin
        if (e) begin
          good = intol ? good + 1 : 0;
          if (good >= LE) begin st = S_LOCKED; good = 0; end
        end else if (tmo) begin st = S_SEARCH; good = 0; end
      end else if (st == S_LOCKED) begin
        if ((e && !intol) || tmo) st = S_LOST;
      end else if (e) begin
        st = S_ACQ; good = 0;
      end
      d3 = d2; d2 = d1; d1 = bus.state_clk;
    end
  end

  always @(negedge clk) begin
    n_chk++;
    if (bus.tick_rise !== m_rise || bus.tick_fall !== m_fall || bus.meas_valid !== m_mv ||
        bus.locked !== m_locked || bus.lost !== m_lost || bus.half_period !== W'(m_half) ||
        bus.edge_count !== 16'(m_ecnt)) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL cycle_compare t=%0t got rf%b%b v%b lk%b ls%b hp%0d ec%0d expected rf%b%b v%b lk%b ls%b hp%0d ec%0d",
                 $time, bus.tick_rise, bus.tick_fall, bus.meas_valid, bus.locked, bus.lost, bus.half_period,
                 bus.edge_count, m_rise, m_fall, m_mv, m_locked, m_lost, m_half, m_ecnt);
    end
  end

  always @(negedge clk)
    if (rst) mv_cnt = 0;
    else if (bus.meas_valid) mv_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    since++;
  endtask

  task automatic tog_after(input int h);
    while (since < h) step();
    bus.state_clk = ~bus.state_clk;
    since = 0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.state_clk = 0;
    #1 rst = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      bus.state_clk = ~bus.state_clk;
      chk("reset_flags", {bus.tick_rise, bus.tick_fall, bus.meas_valid, bus.locked, bus.lost}, 0);
      chk("reset_hp_ec", bus.half_period + bus.edge_count, 0);
    end
    bus.state_clk = 0;
    step();
    rst = 0;
    repeat (3) step();
    chk("search_after_reset", {bus.locked, bus.lost, bus.edge_count}, 0);

    bus.state_clk = 1;
    since = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("latency_rise", bus.tick_rise, i == 3);
      chk("latency_fall", bus.tick_fall, 0);
    end
    tog_after(10);
    tog_after(10);
    repeat (3) step();
    chk("lock_not_yet", bus.locked, 0);
    step();
    chk("lock_locked", bus.locked, 1);
    chk("lock_meas_count", mv_cnt, 2);
    chk("lock_half", bus.half_period, 10);

    tog_after(9);
    tog_after(11);
    repeat (4) step();
    chk("tol_still_locked", bus.locked, 1);
    chk("tol_half_11", bus.half_period, 11);
    tog_after(12);
    repeat (4) step();
    chk("tol_lost", bus.lost, 1);
    chk("tol_unlocked", bus.locked, 0);
    chk("tol_half_12", bus.half_period, 12);

    tog_after(10);
    tog_after(10);
    tog_after(10);
    repeat (4) step();
    chk("relock", bus.locked, 1);
    while (since < 15) step();
    chk("stall_not_lost_yet", bus.lost, 0);
    step();
    chk("stall_lost", bus.lost, 1);
    chk("stall_unlocked", bus.locked, 0);
    tog_after(20);
    tog_after(10);
    tog_after(10);
    repeat (4) step();
    chk("stall_relock", bus.locked, 1);

    rst = 1;
    #1;
    chk("midrun_reset_locked", bus.locked, 0);
    chk("midrun_reset_count", bus.edge_count, 0);
    bus.state_clk = 0;
    repeat (2) step();
    rst = 0;
    since = 0;
    tog_after(10);
    tog_after(10);
    repeat (4) step();
    chk("midrun_partial", bus.locked, 0);
    tog_after(10);
    repeat (4) step();
    chk("midrun_relock", bus.locked, 1);

    rst = 1;
    bus.state_clk = 0;
    repeat (2) step();
    rst = 0;
    step();
    for (int i = 0; i < 65536; i++) begin
      bus.state_clk = ~bus.state_clk;
      step();
    end
    step();
    chk("count_ffff", bus.edge_count, 65535);
    step();
    chk("count_wrap", bus.edge_count, 0);

    since = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1;
        bus.state_clk = 1'($urandom_range(0, 1));
        repeat (2) step();
        rst = 0;
        since = 0;
      end else if (r < 15) tog_after($urandom_range(12, 30));
      else if (r < 30) tog_after($urandom_range(1, 8));
      else tog_after($urandom_range(9, 11));
    end
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
